// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer.
// Issues a held read request at the current PC, latches the returned word into
// IR, and advances the PC by one halfword pair. A controller redirect (wpc)
// reloads the PC and aborts any in-flight request.
// Optional build macro FETCH_TIMEOUT_EN: bounds the wait for mem_ack to
// TIMEOUT_CYCLES REQ cycles. On expiry the unit parks in ERR, with fetch_err
// set, until reset.
module fetch_unit #(
  parameter logic [15:0] RESET_PC       = 16'h0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wir,
  input  logic        wpc,
  input  logic [15:0] pc_in,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] IR,
  output logic        ir_valid,
  output logic [15:0] pc,
  output logic        busy,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] redirect_pc;
  logic        unused_pc0;

  // Redirect targets are forced to halfword-pair alignment
  assign redirect_pc = {pc_in[15:1], 1'b0};
  assign unused_pc0  = pc_in[0];

  // Outputs are pure decodes of the registered state
  assign mem_req  = (state == S_REQ);
  assign busy     = (state == S_REQ);
  assign ir_valid = (state == S_DONE);
  // The PC only moves on ack or abort, so it doubles as the stable fetch address
  assign mem_addr = pc;

`ifdef FETCH_TIMEOUT_EN
  logic [15:0] wait_cnt;

  // Fetch sequencer with bounded wait for the memory acknowledge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= {RESET_PC[15:1], 1'b0};
      IR        <= '0;
      wait_cnt  <= '0;
      fetch_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (wpc) pc <= redirect_pc;
          if (wir) begin
            state    <= S_REQ;
            wait_cnt <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_REQ: begin
          if (wpc) begin
            pc    <= redirect_pc;
            state <= S_IDLE;
          end else if (mem_ack) begin
            IR    <= mem_rdata;
            pc    <= pc + 16'd2;
            state <= S_DONE;
          end else if (wait_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            state     <= S_ERR;
            fetch_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_ERR:   state <= S_ERR;
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign fetch_err      = 1'b0;

  // Fetch sequencer; REQ waits indefinitely for the memory acknowledge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= {RESET_PC[15:1], 1'b0};
      IR    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (wpc) pc <= redirect_pc;
          state <= wir ? S_REQ : S_IDLE;
        end
        S_REQ: begin
          if (wpc) begin
            pc    <= redirect_pc;
            state <= S_IDLE;
          end else if (mem_ack) begin
            IR    <= mem_rdata;
            pc    <= pc + 16'd2;
            state <= S_DONE;
          end
        end
        S_ERR:   state <= S_ERR;
        default: state <= S_IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a scoreboard. Stimulus pushes the
// expected request address and the expected IR/PC result, and a negedge monitor
// pops and compares whenever the DUT raises a request or presents ir_valid.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        wir;
  logic        wpc;
  logic [15:0] pc_in;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] IR;
  logic        ir_valid;
  logic [15:0] pc;
  logic        busy;
  logic        fetch_err;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] pc;
  } res_t;

  logic [15:0] addr_q[$];
  res_t        res_q[$];
  int          checks = 0;
  int          errors = 0;

  fetch_unit #(
    .RESET_PC      (16'h0000),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wir      (wir),
    .wpc      (wpc),
    .pc_in    (pc_in),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .IR       (IR),
    .ir_valid (ir_valid),
    .pc       (pc),
    .busy     (busy),
    .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: request-start address, address stability while held, IR/PC results
  logic        prev_req = 1'b0;
  logic [15:0] prev_addr = '0;
  always @(negedge clk) begin
    if (mem_req && !prev_req) begin
      if (addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req actual=%h required=none", mem_addr);
      end else begin
        chk("req_addr", mem_addr, addr_q.pop_front());
      end
    end else if (mem_req && prev_req) begin
      chk("addr_hold", mem_addr, prev_addr);
    end
    if (ir_valid) begin
      if (res_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ir_valid actual=%h required=none", IR);
      end else begin
        res_t r;
        r = res_q.pop_front();
        chk("ir_value", IR, r.ir);
        chk("pc_after", pc, r.pc);
      end
    end
    prev_req  = mem_req;
    prev_addr = mem_addr;
  end

  initial begin
    rst_n = 1'b0; wir = 1'b0; wpc = 1'b0; pc_in = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    step(); step();
    chk("rst_pc", pc, 16'h0000);
    chk("rst_ir", IR, 16'h0000);
    chk("rst_req", {15'd0, mem_req}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_irv", {15'd0, ir_valid}, 16'd0);
    chk("rst_err", {15'd0, fetch_err}, 16'd0);
    rst_n = 1'b1;
    step();

    // Fetch from reset PC, ack one cycle after request
    mem_rdata = 16'h6000;
    addr_q.push_back(16'h0000);
    res_q.push_back('{ir: 16'h6000, pc: 16'h0002});
    wir = 1'b1; step();
    wir = 1'b0;
    chk("t1_busy", {15'd0, busy}, 16'd1);
    step();
    mem_ack = 1'b1; step();
    mem_ack = 1'b0;
    chk("t1_irv_on", {15'd0, ir_valid}, 16'd1);
    step();
    chk("t1_irv_pulse", {15'd0, ir_valid}, 16'd0);

    // Redirect in IDLE to odd target, then zero-latency ack
    wpc = 1'b1; pc_in = 16'h3001; step();
    wpc = 1'b0;
    chk("t2_redir_pc", pc, 16'h3000);
    addr_q.push_back(16'h3000);
    res_q.push_back('{ir: 16'hC000, pc: 16'h3002});
    mem_rdata = 16'hC000; mem_ack = 1'b1; wir = 1'b1; step();
    wir = 1'b0; step();
    mem_ack = 1'b0; step();

    // Redirect and fetch in the same cycle, PC wraps past 16'hFFFE
    addr_q.push_back(16'hFFFE);
    res_q.push_back('{ir: 16'h1234, pc: 16'h0000});
    mem_rdata = 16'h1234;
    wpc = 1'b1; pc_in = 16'hFFFF; wir = 1'b1; step();
    wpc = 1'b0; wir = 1'b0; mem_ack = 1'b1; step();
    mem_ack = 1'b0; step();
    chk("t3_wrap_pc", pc, 16'h0000);

    // Abort: redirect coincident with ack
    addr_q.push_back(16'h0000);
    mem_rdata = 16'hAAAA;
    wir = 1'b1; step();
    wir = 1'b0; wpc = 1'b1; pc_in = 16'h0100; mem_ack = 1'b1; step();
    wpc = 1'b0; mem_ack = 1'b0;
    chk("t4_req_low", {15'd0, mem_req}, 16'd0);
    chk("t4_ir_kept", IR, 16'h1234);
    chk("t4_pc", pc, 16'h0100);
    chk("t4_no_irv", {15'd0, ir_valid}, 16'd0);
    step();
    chk("t4_no_irv2", {15'd0, ir_valid}, 16'd0);

    // Reset while a request is outstanding
    addr_q.push_back(16'h0100);
    wir = 1'b1; step();
    wir = 1'b0; step();
    chk("t5_waiting", {15'd0, mem_req}, 16'd1);
    rst_n = 1'b0; step();
    chk("t5_req_low", {15'd0, mem_req}, 16'd0);
    chk("t5_pc", pc, 16'h0000);
    chk("t5_ir", IR, 16'h0000);
    rst_n = 1'b1; step();

    // Memory never acknowledges
    addr_q.push_back(16'h0000);
    wir = 1'b1; step();
    wir = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    step(); step(); step();
    chk("t6_still_req", {15'd0, mem_req}, 16'd1);
    chk("t6_no_err_yet", {15'd0, fetch_err}, 16'd0);
    step();
    chk("t6_err", {15'd0, fetch_err}, 16'd1);
    chk("t6_req_low", {15'd0, mem_req}, 16'd0);
    wir = 1'b1; step(); step();
    wir = 1'b0;
    chk("t6_wir_ignored", {15'd0, mem_req}, 16'd0);
    chk("t6_err_sticky", {15'd0, fetch_err}, 16'd1);
`else
    for (int unsigned i = 0; i < 20; i++) step();
    chk("t6_req_held", {15'd0, mem_req}, 16'd1);
    chk("t6_no_err", {15'd0, fetch_err}, 16'd0);
`endif
    rst_n = 1'b0; step();
    rst_n = 1'b1; step();
    chk("t6_err_cleared", {15'd0, fetch_err}, 16'd0);
    step();

    chk("addr_q_empty", 16'(addr_q.size()), 16'd0);
    chk("res_q_empty", 16'(res_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
